// File: rtl/lector_tarjeta.sv
// lector_tarjeta: card-reader front end.
//
// Debounces the card-slot sensor, shifts in the card's serial PIN field
// (MSB first) and presents it to the automatic cashier. Waits for the cashier
// to signal completion, then drives the eject motor. It re-arms only after the
// slot has emptied.
//
// Optional feature macro: LECTOR_PARIDAD_EN
//   When defined, one extra even-parity bit is read after the PIN bits. A
//   parity mismatch leaves `pin` untouched, sets `error_lectura` and ejects the
//   card.
//
// Ports:
//   clk              in   system clock, all state changes on the rising edge
//   reset            in   asynchronous, active-low reset
//   sensor_tarjeta   in   card present in slot
//   dato_serie       in   serial card data, MSB first
//   dato_valido      in   one-cycle strobe qualifying dato_serie
//   fin              in   cashier: transaction complete
//   tarjeta_recibida out  card read and pin valid (Moore, ENTREGAR)
//   pin              out  captured PIN (registered)
//   expulsar         out  eject-motor command (Moore, EXPULSAR)
//   error_lectura    out  sticky read-failure flag (registered)
//   estado           out  current FSM state, for debug and checkers
//
// Handshake with the cashier: tarjeta_recibida rises and stays high, with pin
// stable, for as long as the FSM is in ENTREGAR. A single cycle of fin sampled
// high there ends the transaction: on the next cycle tarjeta_recibida is low
// and expulsar is high. fin is ignored in every other state.

module lector_tarjeta #(
  parameter int unsigned N_BITS          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sensor_tarjeta,
  input  logic              dato_serie,
  input  logic              dato_valido,
  input  logic              fin,
  output logic              tarjeta_recibida,
  output logic [N_BITS-1:0] pin,
  output logic              expulsar,
  output logic              error_lectura,
  output logic [2:0]        estado
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BIT_W = $clog2(N_BITS) + 1;

`ifdef LECTOR_PARIDAD_EN
  localparam int unsigned N_READ = N_BITS + 1;
`else
  localparam int unsigned N_READ = N_BITS;
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    LEER     = 3'd2,
    ENTREGAR = 3'd3,
    EXPULSAR = 3'd4
  } state_t;

  state_t state, next_state;

  logic [DEB_W-1:0]  deb_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [N_BITS-1:0] shift_reg;

  logic deb_done;
  logic tmo_done;
  logic last_bit;
  logic parity_ok;
  logic [N_BITS-1:0] capture;

  always_comb begin
    deb_done = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    tmo_done = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    last_bit = dato_valido && (bit_cnt == BIT_W'(N_READ - 1));
`ifdef LECTOR_PARIDAD_EN
    // The shift register already holds all PIN bits when the parity bit
    // arrives; even parity means the parity bit equals the XOR of the PIN.
    parity_ok = ((^shift_reg) == dato_serie);
    capture   = shift_reg;
`else
    parity_ok = 1'b1;
    capture   = {shift_reg[N_BITS-2:0], dato_serie};
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (sensor_tarjeta) next_state = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!sensor_tarjeta) next_state = IDLE;
        else if (deb_done)   next_state = LEER;
      end
      LEER: begin
        // Card removal beats a completing bit, which beats the timeout.
        if (!sensor_tarjeta) next_state = IDLE;
        else if (last_bit)   next_state = parity_ok ? ENTREGAR : EXPULSAR;
        else if (tmo_done)   next_state = EXPULSAR;
      end
      ENTREGAR: begin
        if (fin)                  next_state = EXPULSAR;
        else if (!sensor_tarjeta) next_state = IDLE;
      end
      EXPULSAR: begin
        if (!sensor_tarjeta) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    tarjeta_recibida = (state == ENTREGAR);
    expulsar         = (state == EXPULSAR);
    estado           = state;
  end

  // Datapath: counters, shift register, captured PIN and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_cnt       <= '0;
      tmo_cnt       <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      pin           <= '0;
      error_lectura <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The error flag stays visible while idle and is cleared only when
          // a new card starts debouncing.
          if (sensor_tarjeta) begin
            error_lectura <= 1'b0;
            deb_cnt       <= '0;
          end
        end
        DEBOUNCE: begin
          if (sensor_tarjeta) begin
            if (deb_done) begin
              bit_cnt   <= '0;
              tmo_cnt   <= '0;
              shift_reg <= '0;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end
        end
        LEER: begin
          if (!sensor_tarjeta) begin
            error_lectura <= 1'b1;
          end else if (last_bit) begin
            if (parity_ok) pin <= capture;
            else           error_lectura <= 1'b1;
          end else if (tmo_done) begin
            error_lectura <= 1'b1;
          end else begin
            // Timeout counts every cycle in LEER, strobes or not.
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (dato_valido) begin
              shift_reg <= {shift_reg[N_BITS-2:0], dato_serie};
              bit_cnt   <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
